axis_slip_deframer: RTL and testbench

Receive-side SLIP (RFC 1055) deframer sitting directly downstream of the UART receiver's master AXI-Stream port. It consumes the raw byte stream and removes END/ESC framing. It emits decoded packets as AXI-Stream with `tlast` on the final byte and `tuser` flagging aborted frames. Frame and error counters are exported for status registers.

---
 rtl/slip_pkg.sv | 23 ++
 rtl/axis_slip_deframer.sv | 184 ++++++++++++++++++
 tb/tb_axis_slip_deframer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/slip_pkg.sv
// ---------------------------------------------------------------------------
// slip_pkg : SLIP framing constants and deframer state encoding
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package slip_pkg;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_ESC     = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/axis_slip_deframer.sv
// ---------------------------------------------------------------------------
// axis_slip_deframer : SLIP byte-stream to AXI-Stream packet deframer
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_slip_deframer
  import slip_pkg::*;
#(
  parameter int MAX_FRAME_LEN = 1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [8:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        rx_error,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [31:0] frame_count,
  output logic [15:0] error_count
);

  localparam int LEN_W = $clog2(MAX_FRAME_LEN + 2);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_LEN);

  state_t           state, state_n, abort_state;
  logic             hold_valid, hold_valid_n;
  logic [7:0]       hold_data, hold_data_n;
  logic [LEN_W-1:0] len, len_n;
  logic             rx_error_q, err_pend, err_pend_n;
  logic             err_edge, err_req, out_free, accept;
  logic             emit, emit_last, emit_user;
  logic             fc_inc, ec_inc;
  logic             do_data, do_abort;
  logic [7:0]       byte_in, dbyte;
  logic             unused_bit;

  assign unused_bit    = s_axis_tdata[8];
  assign byte_in       = s_axis_tdata[7:0];
  assign out_free      = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = out_free;
  assign accept        = s_axis_tvalid & out_free;
  assign err_edge      = rx_error & ~rx_error_q;
  assign err_req       = err_edge | err_pend;

  always_comb begin
    state_n      = state;
    hold_valid_n = hold_valid;
    hold_data_n  = hold_data;
    len_n        = len;
    err_pend_n   = err_pend | err_edge;
    emit         = 1'b0;
    emit_last    = 1'b0;
    emit_user    = 1'b0;
    fc_inc       = 1'b0;
    ec_inc       = 1'b0;
    do_data      = 1'b0;
    do_abort     = 1'b0;
    dbyte        = byte_in;
    abort_state  = ST_DISCARD;

    // An error event is held until the output register can take the abort beat;
    // any beat accepted in that cycle is dropped.
    if (err_req && out_free) begin
      err_pend_n = 1'b0;
      ec_inc     = 1'b1;
      case (state)
        ST_IDLE:         state_n  = ST_DISCARD;
        ST_DATA, ST_ESC: do_abort = 1'b1;
        default:         ;
      endcase
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          if (byte_in == SLIP_ESC)      state_n = ST_ESC;
          else if (byte_in != SLIP_END) do_data = 1'b1;
        end
        ST_DATA: begin
          if (byte_in == SLIP_END) begin
            emit         = 1'b1;
            emit_last    = 1'b1;
            fc_inc       = 1'b1;
            hold_valid_n = 1'b0;
            len_n        = '0;
            state_n      = ST_IDLE;
          end else if (byte_in == SLIP_ESC) begin
            state_n = ST_ESC;
          end else begin
            do_data = 1'b1;
          end
        end
        ST_ESC: begin
          if (byte_in == SLIP_ESC_END) begin
            do_data = 1'b1;
            dbyte   = SLIP_END;
          end else if (byte_in == SLIP_ESC_ESC) begin
            do_data = 1'b1;
            dbyte   = SLIP_ESC;
          end else begin
            do_abort    = 1'b1;
            abort_state = (byte_in == SLIP_END) ? ST_IDLE : ST_DISCARD;
          end
        end
        default: begin
          if (byte_in == SLIP_END) state_n = ST_IDLE;
        end
      endcase
    end

    if (do_data) begin
      if (len == MAX_LEN) begin
        do_abort    = 1'b1;
        abort_state = ST_DISCARD;
      end else begin
        emit         = hold_valid;
        hold_valid_n = 1'b1;
        hold_data_n  = dbyte;
        len_n        = len + 1'b1;
        state_n      = ST_DATA;
      end
    end

    if (do_abort) begin
      emit         = hold_valid;
      emit_last    = 1'b1;
      emit_user    = 1'b1;
      hold_valid_n = 1'b0;
      len_n        = '0;
      ec_inc       = 1'b1;
      state_n      = abort_state;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      len        <= '0;
      rx_error_q <= 1'b0;
      err_pend   <= 1'b0;
    end else begin
      state      <= state_n;
      hold_valid <= hold_valid_n;
      hold_data  <= hold_data_n;
      len        <= len_n;
      rx_error_q <= rx_error;
      err_pend   <= err_pend_n;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (emit) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= hold_data;
      m_axis_tlast  <= emit_last;
      m_axis_tuser  <= emit_user;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_count <= '0;
      error_count <= '0;
    end else begin
      if (fc_inc) frame_count <= frame_count + 32'd1;
      if (ec_inc && error_count != 16'hFFFF) error_count <= error_count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_slip_deframer.sv
// ---------------------------------------------------------------------------
// tb_axis_slip_deframer : directed self-checking bench for axis_slip_deframer
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axis_slip_deframer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        rx_error = 1'b0;
  logic        m_ready;
  logic        tog = 1'b0;
  logic        sel = 1'b0;

  logic        s_ready_a, s_ready_b;
  logic [7:0]  md_a, md_b;
  logic        mv_a, mv_b, ml_a, ml_b, mu_a, mu_b;
  logic [31:0] fc_a, fc_b;
  logic [15:0] ec_a, ec_b;

  logic        s_ready, mv, ml, mu;
  logic [7:0]  md;
  logic [31:0] fc;
  logic [15:0] ec;

  int n_total = 0;
  int n_bad   = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  axis_slip_deframer dut_a (
    .aclk(clk), .aresetn(rst_n), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_ready_a), .rx_error(rx_error), .m_axis_tdata(md_a),
    .m_axis_tvalid(mv_a), .m_axis_tready(m_ready), .m_axis_tlast(ml_a),
    .m_axis_tuser(mu_a), .frame_count(fc_a), .error_count(ec_a)
  );

  axis_slip_deframer #(.MAX_FRAME_LEN(4)) dut_b (
    .aclk(clk), .aresetn(rst_n), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_ready_b), .rx_error(rx_error), .m_axis_tdata(md_b),
    .m_axis_tvalid(mv_b), .m_axis_tready(m_ready), .m_axis_tlast(ml_b),
    .m_axis_tuser(mu_b), .frame_count(fc_b), .error_count(ec_b)
  );

  assign s_ready = sel ? s_ready_b : s_ready_a;
  assign mv      = sel ? mv_b : mv_a;
  assign md      = sel ? md_b : md_a;
  assign ml      = sel ? ml_b : ml_a;
  assign mu      = sel ? mu_b : mu_a;
  assign fc      = sel ? fc_b : fc_a;
  assign ec      = sel ? ec_b : ec_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Downstream ready: constant high, or toggling every cycle when tog is set.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 m_ready = tog ? ~m_ready : 1'b1;
    end
  end

  // Output monitor: scoreboard compare on handshake and stability while stalled.
  initial begin
    logic       stall_q;
    logic [10:0] held;
    logic [9:0] e;
    stall_q = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall_q) check("hold_stable", {21'd0, mv, md, ml, mu}, {21'd0, held});
        if (mv && m_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", {22'd0, md, ml, mu}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("beat", {22'd0, md, ml, mu}, {22'd0, e});
          end
        end
        stall_q = mv && !m_ready;
        held    = {mv, md, ml, mu};
      end else begin
        stall_q = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    s_tvalid = 1'b0;
    rx_error = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    logic ok;
    int   n;
    s_tdata  = {1'b1, b};
    s_tvalid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int cycles);
    s_tvalid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l, input logic u);
    exp_q.push_back({d, l, u});
  endtask

  task automatic finish_case(input string tag, input int fcx, input int ecx);
    idle(30);
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_frames"}, fc, fcx);
    check({tag, "_errors"}, {16'd0, ec}, ecx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_tvalid", mv, 0);
    check("rst_tready", s_ready, 1);
    check("rst_tdata", md, 0);
    check("rst_tlast_user", {ml, mu}, 0);
    check("rst_frames", fc, 0);
    check("rst_errors", {16'd0, ec}, 0);

    // Plain frame with leading END, plus END-to-tlast latency.
    expect_beat(8'h01, 0, 0);
    expect_beat(8'h02, 0, 0);
    expect_beat(8'h03, 1, 0);
    send(8'hC0); send(8'h01); send(8'h02); send(8'h03); send(8'hC0);
    check("lat_tvalid_tlast", {mv, ml, md}, {2'b11, 8'h03});
    finish_case("plain", 1, 0);

    // Escaped END and ESC inside a frame.
    do_reset();
    expect_beat(8'hC0, 0, 0);
    expect_beat(8'hDB, 1, 0);
    send(8'hC0); send(8'hDB); send(8'hDC); send(8'hDB); send(8'hDD); send(8'hC0);
    finish_case("escape", 1, 0);

    // Bad escape aborts, rest discarded until END, next frame good.
    do_reset();
    expect_beat(8'h01, 1, 1);
    expect_beat(8'h05, 1, 0);
    send(8'h01); send(8'hDB); send(8'h55); send(8'h02); send(8'hC0);
    send(8'h05); send(8'hC0);
    finish_case("bad_esc", 1, 1);

    // Empty frames produce nothing.
    do_reset();
    send(8'hC0); send(8'hC0); send(8'hC0);
    finish_case("empty", 0, 0);

    // Over-length frame on the MAX_FRAME_LEN=4 instance.
    do_reset();
    sel = 1'b1;
    expect_beat(8'h11, 0, 0);
    expect_beat(8'h22, 0, 0);
    expect_beat(8'h33, 0, 0);
    expect_beat(8'h44, 1, 1);
    expect_beat(8'h77, 1, 0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    send(8'hC0);
    send(8'h77); send(8'hC0);
    finish_case("overlen", 1, 1);

    // Exactly MAX_FRAME_LEN bytes is accepted.
    do_reset();
    for (int i = 0; i < 4; i++) expect_beat(8'h40 + 8'(i), (i == 3), 0);
    for (int i = 0; i < 4; i++) send(8'h40 + 8'(i));
    send(8'hC0);
    finish_case("maxlen", 1, 0);
    sel = 1'b0;

    // Backpressure: ready toggling during a 10-byte frame.
    do_reset();
    tog = 1'b1;
    for (int i = 0; i < 10; i++) expect_beat(8'h10 + 8'(i), (i == 9), 0);
    for (int i = 0; i < 10; i++) send(8'h10 + 8'(i));
    send(8'hC0);
    idle(10);
    tog = 1'b0;
    finish_case("stall", 1, 0);

    // UART error mid-frame.
    do_reset();
    expect_beat(8'h01, 0, 0);
    expect_beat(8'h02, 1, 1);
    send(8'h01); send(8'h02);
    s_tvalid = 1'b0;
    rx_error = 1'b1;
    @(posedge clk);
    #1 rx_error = 1'b0;
    send(8'h03); send(8'hC0);
    finish_case("rx_err", 0, 1);

    // UART error while idle, then a good frame.
    do_reset();
    expect_beat(8'h09, 1, 0);
    rx_error = 1'b1;
    @(posedge clk);
    #1 rx_error = 1'b0;
    send(8'h08); send(8'hC0); send(8'h09); send(8'hC0);
    finish_case("rx_err_idle", 1, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
